// File: rtl/aes_mixcols_seq_if.sv
// Handshake and data bundle between the AES round datapath and the MixColumns sequencer.
interface aes_mixcols_seq_if;
    logic         start_i;
    logic         inv_i;
    logic         bypass_i;
    logic         flush_i;
    logic [127:0] state_i;
    logic [127:0] state_o;
    logic         valid_o;
    logic         ready_o;
    logic         busy_o;

    modport master (
        output start_i, inv_i, bypass_i, flush_i, state_i,
        input  state_o, valid_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, inv_i, bypass_i, flush_i, state_i,
        output state_o, valid_o, ready_o, busy_o
    );
endinterface

// File: rtl/aes_mixcols_seq.sv
// AES (Inv)MixColumns sequencer: one shared 32-bit column mixer, one column per cycle.
module aes_mixcols_seq (
    input  logic               clk,
    input  logic               rst,
    aes_mixcols_seq_if.slave   bus
);
    localparam int unsigned COL_W  = 32;
    localparam int unsigned N_COLS = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                  r_state;
    logic [1:0]                  r_col;
    logic [N_COLS-1:0][COL_W-1:0] r_wbuf;
    logic                        r_inv;
    logic [127:0]                r_state_o;

    logic [1:0]                  w_state_nxt;
    logic [1:0]                  w_col_nxt;
    logic [N_COLS-1:0][COL_W-1:0] w_wbuf_nxt;
    logic                        w_inv_nxt;
    logic [127:0]                w_state_o_nxt;
    logic [COL_W-1:0]            w_col_in;
    logic [COL_W-1:0]            w_mix;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // One output row; a0 is the byte in the same row, a1..a3 the following rows (mod 4).
    function automatic logic [7:0] mix_row(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3,
                                           input logic inv);
        logic [7:0] x2_0, x4_0, x8_0;
        logic [7:0] x2_1, x4_1, x8_1;
        logic [7:0] x2_2, x4_2, x8_2;
        logic [7:0] x2_3, x4_3, x8_3;
        x2_0 = xtime(a0); x4_0 = xtime(x2_0); x8_0 = xtime(x4_0);
        x2_1 = xtime(a1); x4_1 = xtime(x2_1); x8_1 = xtime(x4_1);
        x2_2 = xtime(a2); x4_2 = xtime(x2_2); x8_2 = xtime(x4_2);
        x2_3 = xtime(a3); x4_3 = xtime(x2_3); x8_3 = xtime(x4_3);
        if (inv) begin
            // 0E*a0 ^ 0B*a1 ^ 0D*a2 ^ 09*a3
            return (x8_0 ^ x4_0 ^ x2_0) ^ (x8_1 ^ x2_1 ^ a1) ^
                   (x8_2 ^ x4_2 ^ a2)   ^ (x8_3 ^ a3);
        end
        // 02*a0 ^ 03*a1 ^ a2 ^ a3
        return x2_0 ^ (x2_1 ^ a1) ^ a2 ^ a3;
    endfunction

    // Column mixer on the column currently selected by r_col.
    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        w_col_in = r_wbuf[r_col];
        b0 = w_col_in[7:0];
        b1 = w_col_in[15:8];
        b2 = w_col_in[23:16];
        b3 = w_col_in[31:24];
        w_mix = {mix_row(b3, b0, b1, b2, r_inv),
                 mix_row(b2, b3, b0, b1, r_inv),
                 mix_row(b1, b2, b3, b0, r_inv),
                 mix_row(b0, b1, b2, b3, r_inv)};
    end

    // Next-state and datapath update logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_wbuf_nxt    = r_wbuf;
        w_inv_nxt     = r_inv;
        w_state_o_nxt = r_state_o;
        case (r_state)
            S_IDLE: begin
                // flush wins over start: a simultaneous request is dropped
                if (bus.start_i && !bus.flush_i) begin
                    w_wbuf_nxt = bus.state_i;
                    w_inv_nxt  = bus.inv_i;
                    if (bus.bypass_i) begin
                        w_state_o_nxt = bus.state_i;
                        w_state_nxt   = S_DONE;
                    end else begin
                        w_col_nxt   = 2'd0;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.flush_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wbuf_nxt[r_col] = w_mix;
                    w_col_nxt         = 2'(r_col + 2'd1);
                    if (r_col == 2'd3) begin
                        // last column goes straight to the output register
                        w_state_o_nxt = {w_mix, r_wbuf[2], r_wbuf[1], r_wbuf[0]};
                        w_state_nxt   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_col     <= 2'd0;
            r_wbuf    <= '0;
            r_inv     <= 1'b0;
            r_state_o <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_wbuf    <= w_wbuf_nxt;
            r_inv     <= w_inv_nxt;
            r_state_o <= w_state_o_nxt;
        end
    end

    // Status outputs decoded from the state register only.
    assign bus.state_o = r_state_o;
    assign bus.valid_o = (r_state == S_DONE);
    assign bus.ready_o = (r_state == S_IDLE);
    assign bus.busy_o  = (r_state == S_RUN) || (r_state == S_DONE);
endmodule

// File: tb/tb_aes_mixcols_seq.sv
// Self-checking bench for aes_mixcols_seq: vector table, random round trips, corner sequences.
module tb_aes_mixcols_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [127:0] last_out;

    localparam logic [127:0] C1_IN  = 128'hC6C6C6C6_01010101_5C220AF2_455313DB;
    localparam logic [127:0] C1_OUT = 128'hC6C6C6C6_01010101_9D58DC9F_BCA14D8E;
    localparam logic [127:0] BYP_IN = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    aes_mixcols_seq_if bus();

    aes_mixcols_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model: generic GF(2^8) multiply over the circulant coefficient rows.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   b  [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (inv) cf = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) b[r] = s[32*c + 8*r +: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[j], b[(r + j) % 4]);
                o[32*c + 8*r +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Issue one request from IDLE (called just after a negedge) and watch 8 cycles.
    task automatic run_op(input logic inv, input logic byp, input logic [127:0] din,
                          input logic [127:0] exp, input string nm);
        int lat;
        int vcyc;
        int vcnt;
        lat  = byp ? 1 : 5;
        vcyc = 0;
        vcnt = 0;
        chk({nm, ".ready_pre"}, 128'(bus.ready_o), 128'd1);
        bus.inv_i    = inv;
        bus.bypass_i = byp;
        bus.state_i  = din;
        bus.start_i  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start_i = 1'b0;
                chk({nm, ".busy"}, 128'(bus.busy_o), 128'd1);
            end
            if (bus.valid_o) begin
                vcnt++;
                if (vcyc == 0) vcyc = k;
            end
            if (k == lat - 1) chk({nm, ".hold"}, bus.state_o, last_out);
            if (k == lat)     chk({nm, ".state_o"}, bus.state_o, exp);
            if (k == lat + 1) chk({nm, ".ready_back"}, 128'(bus.ready_o), 128'd1);
        end
        chk({nm, ".valid_cycle"}, 128'(vcyc), 128'(lat));
        chk({nm, ".valid_count"}, 128'(vcnt), 128'd1);
        last_out = exp;
    endtask

    typedef struct {
        logic         inv;
        logic         byp;
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [127:0] s;
        logic [127:0] f;
        logic [127:0] s2;
        int           v5;
        int           v11;
        int           vcnt;

        vecs[0] = '{1'b0, 1'b0, C1_IN,  C1_OUT};
        vecs[1] = '{1'b1, 1'b0, C1_OUT, C1_IN};
        vecs[2] = '{1'b0, 1'b1, BYP_IN, BYP_IN};
        vecs[3] = '{1'b0, 1'b0, 128'd0, 128'd0};
        vecs[4] = '{1'b1, 1'b1, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
                                128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D};
        vecs[5] = '{1'b1, 1'b0, 128'h01010101_01010101_01010101_01010101,
                                128'h01010101_01010101_01010101_01010101};

        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.inv_i    = 1'b0;
        bus.bypass_i = 1'b0;
        bus.flush_i  = 1'b0;
        bus.state_i  = '0;
        last_out     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("reset.state_o", bus.state_o, 128'd0);
        chk("reset.valid",   128'(bus.valid_o), 128'd0);
        chk("reset.busy",    128'(bus.busy_o),  128'd0);
        chk("reset.ready",   128'(bus.ready_o), 128'd1);

        // vector table
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("vec%0d.model", i), model_mix(vecs[i].din, vecs[i].inv) ^ 128'd0,
                vecs[i].byp ? model_mix(vecs[i].din, vecs[i].inv) : vecs[i].dexp);
            run_op(vecs[i].inv, vecs[i].byp, vecs[i].din, vecs[i].dexp, $sformatf("vec%0d", i));
        end

        // random forward/inverse round trips
        for (int i = 0; i < 1000; i++) begin
            s = rnd128();
            f = model_mix(s, 1'b0);
            run_op(1'b0, 1'b0, s, f, "rnd.fwd");
            run_op(1'b1, 1'b0, f, s, "rnd.inv");
        end

        // start held high, mode/state toggled during RUN; back-to-back second request
        s2           = rnd128();
        v5           = 0;
        v11          = 0;
        vcnt         = 0;
        bus.inv_i    = 1'b0;
        bus.bypass_i = 1'b0;
        bus.state_i  = C1_IN;
        bus.start_i  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                vcnt++;
                if (k == 5)  v5 = 1;
                if (k == 11) v11 = 1;
            end
            if (k <= 5) begin
                bus.inv_i   = ~bus.inv_i;
                bus.state_i = rnd128();
            end
            if (k == 5) chk("hold_start.first", bus.state_o, C1_OUT);
            if (k == 6) begin
                chk("hold_start.ready6", 128'(bus.ready_o), 128'd1);
                bus.inv_i   = 1'b0;
                bus.state_i = s2;
            end
            if (k == 7) begin
                bus.start_i = 1'b0;
                bus.state_i = rnd128();
                bus.inv_i   = 1'b1;
            end
            if (k == 11) chk("hold_start.second", bus.state_o, model_mix(s2, 1'b0));
        end
        chk("hold_start.v5",    128'(v5),   128'd1);
        chk("hold_start.v11",   128'(v11),  128'd1);
        chk("hold_start.count", 128'(vcnt), 128'd2);
        last_out = model_mix(s2, 1'b0);

        // flush in T+2
        vcnt         = 0;
        bus.inv_i    = 1'b0;
        bus.state_i  = rnd128();
        bus.start_i  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus.start_i = 1'b0;
            if (bus.valid_o) vcnt++;
            if (k == 2) bus.flush_i = 1'b1;
            if (k == 3) begin
                bus.flush_i = 1'b0;
                chk("flush.ready", 128'(bus.ready_o), 128'd1);
                chk("flush.busy",  128'(bus.busy_o),  128'd0);
            end
        end
        chk("flush.no_valid", 128'(vcnt), 128'd0);
        chk("flush.state_o",  bus.state_o, last_out);

        // flush and start together in IDLE
        vcnt         = 0;
        bus.state_i  = rnd128();
        bus.flush_i  = 1'b1;
        bus.start_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        chk("flush_start.ready", 128'(bus.ready_o), 128'd1);
        chk("flush_start.busy",  128'(bus.busy_o),  128'd0);
        for (int k = 0; k < 6; k++) begin
            if (bus.valid_o) vcnt++;
            @(negedge clk);
        end
        chk("flush_start.no_valid", 128'(vcnt), 128'd0);
        chk("flush_start.state_o",  bus.state_o, last_out);

        // reset in T+3
        bus.state_i = C1_IN;
        bus.inv_i   = 1'b0;
        bus.start_i = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) bus.start_i = 1'b0;
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                rst = 1'b0;
                chk("rst_mid.state_o", bus.state_o, 128'd0);
                chk("rst_mid.valid",   128'(bus.valid_o), 128'd0);
                chk("rst_mid.busy",    128'(bus.busy_o),  128'd0);
                chk("rst_mid.ready",   128'(bus.ready_o), 128'd1);
            end
        end
        last_out = '0;
        run_op(1'b0, 1'b0, C1_IN, C1_OUT, "rst_mid.rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_mixcols_seq.md
# aes_mixcols_seq

Multi-cycle sequencer that applies AES MixColumns or InvMixColumns to a full 128-bit AES state using one shared 32-bit column mixer, one column per cycle. It sits between the AES round-state register and the round-key XOR in the AES coprocessor datapath. It accepts one state per start handshake, walks columns 0..3 and returns the whole result with a one-cycle valid pulse. A bypass mode handles the final round, which has no MixColumns.

## Interface
- No parameters; datapath width is fixed at 128 bits, four 32-bit columns.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: request; sampled only when `ready_o`=1.
- `inv_i` in 1: 0 = MixColumns, 1 = InvMixColumns; captured with `start_i`.
- `bypass_i` in 1: 1 = pass state through unmixed; captured with `start_i`.
- `flush_i` in 1: abort the current operation.
- `state_i` in 128: input state; column c = `state_i[32c+31:32c]`; within a column, byte r (row r) = bits `[8r+7:8r]`.
- `state_o` out 128: result register, same packing as `state_i`.
- `valid_o` out 1: one-cycle pulse, `state_o` is new.
- `ready_o` out 1: block is in IDLE and accepts `start_i`.
- `busy_o` out 1: block is in RUN or DONE.

## Operation
- **FSM states:** IDLE, RUN, DONE. Column counter `col` is 2 bits.
- **IDLE:**
  - `ready_o`=1.
  - On `start_i`=1, capture `state_i` into the working buffer `wbuf`, and capture `inv_i` and `bypass_i`.
  - If `bypass_i`=1, load `state_o` <= `state_i` and go to DONE.
  - Otherwise set `col`<=0 and go to RUN.
- **RUN:**
  - The mixer input is `wbuf` column `col`.
  - Each edge writes the mixer output back into `wbuf` column `col` and increments `col`.
  - On the edge where `col`==3: load `state_o` with `wbuf` columns 0..2 plus the column-3 mixer output, then go to DONE. `col` wraps to 0.
- **DONE:** `valid_o`=1 for exactly this cycle, then go to IDLE unconditionally.
- **Column mixer arithmetic** (combinational, GF(2^8), reduction polynomial 0x11B, xtime(a) = (a<<1) ^ (a[7] ? 0x1B : 0)):
  - Forward: out_r = 2·b_r ^ 3·b_(r+1) ^ b_(r+2) ^ b_(r+3). Indices are mod 4.
  - Inverse: out_r = 0E·b_r ^ 0B·b_(r+1) ^ 0D·b_(r+2) ^ 09·b_(r+3).
- **`state_o` hold rule:** `state_o` changes only on a DONE-entry load or on reset. It holds through IDLE, RUN and flush. Partial results are never visible on `state_o`.
- **Mode stability:** `inv_i`, `bypass_i` and `state_i` changes during RUN/DONE have no effect. Only the values captured at accept are used.
- **`flush_i`** (RUN or DONE): the next state is IDLE, no `valid_o`, `state_o` unchanged.
- **`flush_i` in IDLE:** `flush_i` has priority over `start_i`. With both high, the request is dropped.
- **`start_i` outside IDLE:** ignored. It is not queued.
- **Reset:**
  - FSM state is IDLE.
  - `col`=0, `wbuf`=0, `state_o`=0.
  - `valid_o`=0, `busy_o`=0, `ready_o`=1 (IDLE).
  - Reset mid-operation discards all progress.

## Timing
- `start_i` is accepted at edge E0, at the end of cycle T.
- **Mix operation:**
  - RUN occupies cycles T+1..T+4.
  - `valid_o`=1 and the new `state_o` appear in cycle T+5.
  - `ready_o` returns in cycle T+6.
- **Bypass:** `valid_o`=1 in cycle T+1; `ready_o` returns in cycle T+2.
- **Throughput:**
  - Mix: one state per 6 cycles.
  - Bypass: one state per 2 cycles.
- **Output decode:** `ready_o`, `busy_o` and `valid_o` are decoded from the FSM state register only. There is no combinational path from any input.
- **Critical path:** `wbuf` column mux -> inverse mixer (three xtime levels plus XOR tree) -> `wbuf`/`state_o` write.

## Test plan
1. **Forward mix, identity columns.** Reset, then start with `inv`=0 and columns {0x455313DB, 0x5C220AF2, 0x01010101, 0xC6C6C6C6}.
   - Required: `valid_o` exactly in cycle T+5.
   - Required: `state_o` = {0xBCA14D8E, 0x9D58DC9F, 0x01010101, 0xC6C6C6C6}.
2. **Inverse mix round trip.** Start with `inv`=1 on the case-1 result.
   - Required: `state_o` returns to the case-1 input.
   - Required: forward followed by inverse on random states is the identity (1000 iterations).
3. **Bypass.** Start with `bypass`=1 and `state_i`=0x00112233_44556677_8899AABB_CCDDEEFF.
   - Required: `valid_o` in T+1 with `state_o` equal to the input.
   - Required: `ready_o` back high in T+2.
4. **Ignored start and input changes.** Pulse `start_i`, then toggle `inv_i`/`state_i` and hold `start_i` high during RUN.
   - Required: a single `valid_o` with the case-1 result.
   - Required: the second request is accepted only in T+6 (a back-to-back second result appears in T+11).
5. **Flush.** Assert `flush_i` in cycle T+2.
   - Required: IDLE in T+3, no `valid_o`, `state_o` still holds its previous value.
   - Required: assert `flush_i` together with `start_i` in IDLE → no acceptance.
6. **Reset mid-RUN.** Assert `rst` in T+3.
   - Required: next cycle `state_o`=0, `valid_o`=0, `busy_o`=0, `ready_o`=1.
   - Required: a subsequent start behaves as in case 1.
